// File: rtl/apb_pkg.sv
// Shared definitions for the APB requester blocks: FSM encoding, default bus
// sizes and the byte-strobe width helper.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10,
        RESP   = 2'b11
    } apb_state_e;

    localparam int APB_DATA_SIZE = 32;
    localparam int APB_ADDR_SIZE = 6;

    function automatic int strb_width(input int data_size);
        return data_size / 8;
    endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS wait cycles and flags the cycle on which the wait limit is hit.
// TIMEOUT=0 disables the limit entirely.
module apb_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int CW    = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam int LIMIT = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt_q <= '0;
        end else if (count_en) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // Fires on the wait cycle whose increment would make the count reach TIMEOUT.
    assign expired = (TIMEOUT != 0) && count_en && (cnt_q == CW'(LIMIT));

endmodule

// File: rtl/apb_master_bridge.sv
// APB4 requester: one valid/ready command becomes one SETUP/ACCESS transfer,
// and its read data / error status comes back on a valid/ready response.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int DATA_SIZE = APB_DATA_SIZE,
    parameter int ADDR_SIZE = APB_ADDR_SIZE,
    parameter int TIMEOUT   = 16
) (
    input  logic                               PCLK,
    input  logic                               PRESET,
    input  logic                               cmd_valid,
    output logic                               cmd_ready,
    input  logic                               cmd_write,
    input  logic [ADDR_SIZE-1:0]               cmd_addr,
    input  logic [DATA_SIZE-1:0]               cmd_wdata,
    input  logic [strb_width(DATA_SIZE)-1:0]   cmd_strobe,
    output logic                               rsp_valid,
    input  logic                               rsp_ready,
    output logic [DATA_SIZE-1:0]               rsp_rdata,
    output logic                               rsp_err,
    output logic                               rsp_timeout,
    output logic [ADDR_SIZE-1:0]               PADDR,
    output logic                               PSEL,
    output logic                               PENABLE,
    output logic                               PWRITE,
    output logic [DATA_SIZE-1:0]               PWDATA,
    output logic [strb_width(DATA_SIZE)-1:0]   PSTROBE,
    input  logic [DATA_SIZE-1:0]               PRDATA,
    input  logic                               PREADY,
    input  logic                               PSLVERR
);

    localparam int SW = strb_width(DATA_SIZE);

    apb_state_e           state_q,       state_d;
    logic                 psel_q,        psel_d;
    logic                 penable_q,     penable_d;
    logic                 pwrite_q,      pwrite_d;
    logic [ADDR_SIZE-1:0] paddr_q,       paddr_d;
    logic [DATA_SIZE-1:0] pwdata_q,      pwdata_d;
    logic [SW-1:0]        pstrobe_q,     pstrobe_d;
    logic                 rsp_valid_q,   rsp_valid_d;
    logic [DATA_SIZE-1:0] rsp_rdata_q,   rsp_rdata_d;
    logic                 rsp_err_q,     rsp_err_d;
    logic                 rsp_timeout_q, rsp_timeout_d;
    logic                 expired;

    apb_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk      (PCLK),
        .rst      (PRESET),
        .clear    (state_q == SETUP),
        .count_en ((state_q == ACCESS) && !PREADY),
        .expired  (expired)
    );

    always_comb begin
        state_d       = state_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        pstrobe_d     = pstrobe_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    paddr_d   = cmd_addr;
                    pwrite_d  = cmd_write;
                    pwdata_d  = cmd_wdata;
                    pstrobe_d = cmd_write ? cmd_strobe : '0;
                    psel_d    = 1'b1;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                // A ready responder takes priority over a timeout on the same cycle.
                if (psel_q && penable_q && PREADY) begin
                    rsp_rdata_d   = pwrite_q ? '0 : PRDATA;
                    rsp_err_d     = PSLVERR;
                    rsp_timeout_d = 1'b0;
                    rsp_valid_d   = 1'b1;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    state_d       = RESP;
                end else if (expired) begin
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_valid_d   = 1'b1;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    state_d       = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    pwrite_d    = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q       <= IDLE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pstrobe_q     <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            pstrobe_q     <= pstrobe_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign cmd_ready   = (state_q == IDLE);
    assign PSEL        = psel_q;
    assign PENABLE     = penable_q;
    assign PWRITE      = pwrite_q;
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;
    assign PSTROBE     = pstrobe_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: the bench plays the APB responder and
// the response consumer, with hand-computed expectations per transfer.
module tb_apb_master_bridge;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [5:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_strobe;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [5:0]  PADDR;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PWDATA, PRDATA;
    logic [3:0]  PSTROBE;
    logic        PREADY, PSLVERR;

    int total = 0;
    int bad   = 0;
    logic [31:0] mem [64];

    always #5 PCLK = ~PCLK;

    apb_master_bridge #(.DATA_SIZE(32), .ADDR_SIZE(6), .TIMEOUT(16)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strobe(cmd_strobe),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PSTROBE(PSTROBE), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    typedef struct {
        logic        wr;
        logic [5:0]  addr;
        logic [31:0] wd;
        logic [3:0]  st;
        int          waits;
        logic [31:0] prd;
        logic        err_in;
        int          rdly;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_to;
        int          exp_en;
        int          exp_sel;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] lane_mask(input logic [3:0] st);
        return {{8{st[3]}}, {8{st[2]}}, {8{st[1]}}, {8{st[0]}}};
    endfunction

    function automatic logic [31:0] sweep_wd(input int i);
        return {8'(i), 8'(i + 100), 8'(i ^ 8'h5A), 8'(255 - i)};
    endfunction

    // Starts at #1 after a rising edge with the DUT idle. rdly<0 holds rsp_ready
    // high from the start so the response is consumed on its first cycle.
    task automatic run_xfer(input logic wr, input logic [5:0] addr, input logic [31:0] wd,
                            input logic [3:0] st, input int waits, input logic [31:0] prd,
                            input logic err_in, input int rdly, input logic use_mem,
                            output logic [31:0] o_rdata, output logic o_err, output logic o_to,
                            output int o_en, output int o_sel, output logic o_ok,
                            output logic o_done);
        logic [3:0] exp_st;
        exp_st = wr ? st : 4'h0;
        o_en = 0; o_sel = 0; o_ok = 1'b1; o_done = 1'b0;
        rsp_ready  = (rdly < 0);
        cmd_valid  = 1'b1; cmd_write = wr; cmd_addr = addr;
        cmd_wdata  = wd;   cmd_strobe = st;
        PREADY = 1'b0; PSLVERR = 1'b0;
        if (!cmd_ready) o_ok = 1'b0;
        @(posedge PCLK); #1;
        cmd_valid = 1'b0;
        for (int g = 0; g < 60; g++) begin
            if (rsp_valid) begin
                o_done = 1'b1;
                break;
            end
            if (cmd_ready) o_ok = 1'b0;
            if (PSEL) begin
                o_sel++;
                if (PADDR !== addr || PSTROBE !== exp_st || PWRITE !== wr || PWDATA !== wd)
                    o_ok = 1'b0;
            end
            if (PSEL && PENABLE) begin
                o_en++;
                if (o_en > waits) begin
                    PREADY  = 1'b1;
                    PSLVERR = err_in;
                    PRDATA  = use_mem ? mem[PADDR] : prd;
                    if (use_mem && wr)
                        mem[PADDR] = (mem[PADDR] & ~lane_mask(PSTROBE)) | (PWDATA & lane_mask(PSTROBE));
                end else begin
                    PREADY  = 1'b0;
                    PSLVERR = 1'b1;
                    PRDATA  = prd;
                end
            end
            @(posedge PCLK); #1;
            PREADY = 1'b0; PSLVERR = 1'b0;
        end
        o_rdata = rsp_rdata; o_err = rsp_err; o_to = rsp_timeout;
        if (cmd_ready || PSEL || PENABLE) o_ok = 1'b0;
        for (int k = 0; k < rdly; k++) begin
            if (cmd_ready || PSEL || PENABLE || !rsp_valid || rsp_rdata !== o_rdata ||
                rsp_err !== o_err || rsp_timeout !== o_to)
                o_ok = 1'b0;
            @(posedge PCLK); #1;
        end
        rsp_ready = 1'b1;
        @(posedge PCLK); #1;
        rsp_ready = 1'b0;
        if (rsp_valid || !cmd_ready || PWRITE || PSEL || PADDR !== addr) o_ok = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] r;
        logic        e, t, ok, done;
        int          en, sel;

        //            wr    addr   wd            st    w   prd           err   rdly  exp_rd        ee    et    en  sel
        vecs[0] = '{1'b1, 6'h05, 32'h55555555, 4'hF, 0,  32'h00000000, 1'b0, 0,  32'h00000000, 1'b0, 1'b0, 1,  2};
        vecs[1] = '{1'b0, 6'h05, 32'h00000000, 4'hF, 3,  32'hDEADBEEF, 1'b0, 0,  32'hDEADBEEF, 1'b0, 1'b0, 4,  5};
        vecs[2] = '{1'b1, 6'h3F, 32'h12345678, 4'h5, 0,  32'hFFFFFFFF, 1'b1, 2,  32'h00000000, 1'b1, 1'b0, 1,  2};
        vecs[3] = '{1'b0, 6'h0A, 32'h00000000, 4'h0, 16, 32'hCAFEF00D, 1'b0, 1,  32'h00000000, 1'b1, 1'b1, 16, 17};
        vecs[4] = '{1'b0, 6'h0B, 32'h00000000, 4'h3, 15, 32'h0BADF00D, 1'b0, -1, 32'h0BADF00D, 1'b0, 1'b0, 16, 17};
        vecs[5] = '{1'b0, 6'h3F, 32'hA0A0A0A0, 4'hF, 2,  32'h13572468, 1'b1, 3,  32'h13572468, 1'b1, 1'b0, 3,  4};
        vecs[6] = '{1'b1, 6'h00, 32'hFFFFFFFF, 4'h0, 1,  32'h11111111, 1'b0, 0,  32'h00000000, 1'b0, 1'b0, 2,  3};

        PRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_strobe = '0; rsp_ready = 1'b0;
        PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
        repeat (2) @(posedge PCLK);
        #1;
        chk("reset_apb", {26'(0), PSEL, PENABLE, PWRITE, PSTROBE != 4'h0, PADDR != 6'h0, PWDATA != 32'h0}, 32'h0);
        chk("reset_rsp", {28'(0), rsp_valid, rsp_err, rsp_timeout, rsp_rdata != 32'h0}, 32'h0);
        chk("reset_cmd_ready", 32'(cmd_ready), 32'h1);
        PRESET = 1'b0;
        @(posedge PCLK); #1;

        for (int i = 0; i < 7; i++) begin
            run_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].st, vecs[i].waits,
                     vecs[i].prd, vecs[i].err_in, vecs[i].rdly, 1'b0,
                     r, e, t, en, sel, ok, done);
            chk($sformatf("v%0d_done", i),     32'(done), 32'h1);
            chk($sformatf("v%0d_rdata", i),    r, vecs[i].exp_rdata);
            chk($sformatf("v%0d_err", i),      32'(e), 32'(vecs[i].exp_err));
            chk($sformatf("v%0d_timeout", i),  32'(t), 32'(vecs[i].exp_to));
            chk($sformatf("v%0d_penable", i),  32'(en), 32'(vecs[i].exp_en));
            chk($sformatf("v%0d_psel", i),     32'(sel), 32'(vecs[i].exp_sel));
            chk($sformatf("v%0d_protocol", i), 32'(ok), 32'h1);
        end

        // Reset during ACCESS wait states.
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 6'h21; cmd_wdata = '0; cmd_strobe = '0;
        @(posedge PCLK); #1;
        cmd_valid = 1'b0;
        repeat (2) begin @(posedge PCLK); #1; end
        chk("midrst_in_access", {30'(0), PSEL, PENABLE}, 32'h3);
        PRESET = 1'b1;
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        chk("midrst_apb", {29'(0), PSEL, PENABLE, PADDR != 6'h0}, 32'h0);
        chk("midrst_rsp", {30'(0), rsp_valid, cmd_ready}, 32'h1);
        run_xfer(1'b0, 6'h07, 32'h0, 4'h0, 1, 32'h76543210, 1'b0, 0, 1'b0, r, e, t, en, sel, ok, done);
        chk("postrst_rdata", r, 32'h76543210);
        chk("postrst_status", {29'(0), done, e, t}, 32'h4);
        chk("postrst_protocol", 32'(ok), 32'h1);

        // Back-to-back writes with alternating response backpressure, then read back.
        for (int a = 0; a < 64; a++) mem[a] = 32'h0;
        for (int i = 0; i < 50; i++) begin
            run_xfer(1'b1, 6'(i), sweep_wd(i), 4'(4 - i), i % 3, 32'h0, 1'b0,
                     (i % 2) ? 5 : 0, 1'b1, r, e, t, en, sel, ok, done);
            chk($sformatf("bp%0d_status", i), {29'(0), done, e, t}, 32'h4);
            chk($sformatf("bp%0d_protocol", i), 32'(ok), 32'h1);
        end
        for (int i = 0; i < 50; i++) begin
            run_xfer(1'b0, 6'(i), 32'h0, 4'hF, 0, 32'h0, 1'b0, 0, 1'b1,
                     r, e, t, en, sel, ok, done);
            chk($sformatf("rb%0d_rdata", i), r, sweep_wd(i) & lane_mask(4'(4 - i)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
